// File: rtl/period_meter_pkg.sv
// Shared types and helpers for the period meter.
// Contents: state_t (IDLE/MEASURE/TIMEOUT) and period_width(), which sizes the
// counter and period_out for a given MAX_COUNT.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  // Bits needed to hold values 0..max_count inclusive.
  function automatic int unsigned period_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/module_sync_edge.sv
// Two-flop synchronizer with a delay stage for transition detection.
// Can be reused for any slow asynchronous input.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   async_in  asynchronous input
//   level_out synchronized level
//   edge_out  one-cycle pulse on every rising or falling transition of level_out
module module_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level_out,
  output logic edge_out
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // Metastability filter followed by a one-cycle delay for the edge compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign level_out = sync2;
  assign edge_out  = sync2 ^ sync2_d;

endmodule

// File: rtl/module_period_meter.sv
// Period meter for a slow asynchronous toggle signal.
// Counts clk cycles between consecutive transitions of tog_in. Each completed
// measurement is reported with a one-cycle strobe. Loss of activity is flagged
// with a timeout level.
// Optional feature macro: PERIOD_METER_LOCK_EN adds the EXPECT/TOL parameters
// and the lock output.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tog_in       asynchronous toggle input
//   period_out   last measured period in clk cycles (1..MAX_COUNT)
//   period_valid one-cycle strobe, period_out updated this cycle
//   timeout      high while no transition has been seen for MAX_COUNT cycles
//   lock         (macro only) last period within EXPECT +/- TOL
module module_period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 2000000
`ifdef PERIOD_METER_LOCK_EN
  ,
  parameter int unsigned EXPECT    = 1000001,
  parameter int unsigned TOL       = 16
`endif
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                tog_in,
  output logic [period_width(MAX_COUNT)-1:0]  period_out,
  output logic                                period_valid,
  output logic                                timeout
`ifdef PERIOD_METER_LOCK_EN
  ,
  output logic                                lock
`endif
);

  localparam int unsigned W = period_width(MAX_COUNT);
  localparam logic [W-1:0] CNT_LAST = W'(MAX_COUNT - 1);

  // The synchronized level is not needed here; the edge pulse carries everything.
  logic         level_unused;
  logic         tog_edge;
  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_inc;

  module_sync_edge u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (tog_in),
    .level_out (level_unused),
    .edge_out  (tog_edge)
  );

  // cnt never exceeds MAX_COUNT-1, so cnt+1 always fits in W bits
  assign cnt_inc = cnt + W'(1);

`ifdef PERIOD_METER_LOCK_EN
  // True when |p - EXPECT| <= TOL
  function automatic logic within_tol(input logic [W-1:0] p);
    logic [31:0] pv;
    logic [31:0] diff;
    pv   = 32'(p);
    diff = (pv >= EXPECT) ? (pv - EXPECT) : (EXPECT - pv);
    return (diff <= TOL);
  endfunction
`endif

  // Measurement FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
`ifdef PERIOD_METER_LOCK_EN
      lock         <= 1'b0;
`endif
    end else begin
      period_valid <= 1'b0;
      case (state)
        // First transition only starts the count; no prior edge to measure from
        IDLE: begin
          if (tog_edge) begin
            cnt   <= '0;
            state <= MEASURE;
          end
        end
        // An edge in the last counting cycle wins over the timeout,
        // which is how a period of exactly MAX_COUNT gets reported
        MEASURE: begin
          if (tog_edge) begin
            period_out   <= cnt_inc;
            period_valid <= 1'b1;
            cnt          <= '0;
`ifdef PERIOD_METER_LOCK_EN
            lock         <= within_tol(cnt_inc);
`endif
          end else if (cnt == CNT_LAST) begin
            state   <= TIMEOUT;
            timeout <= 1'b1;
`ifdef PERIOD_METER_LOCK_EN
            lock    <= 1'b0;
`endif
          end else begin
            cnt <= cnt_inc;
          end
        end
        // Frozen until activity resumes; the resuming edge restarts the count
        TIMEOUT: begin
          if (tog_edge) begin
            cnt     <= '0;
            timeout <= 1'b0;
            state   <= MEASURE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
